mem_port_arbiter: RTL

//  Shares one port of the 4K x 32 dual-port block RAM between two requesters:
//  m0 (CPU load/store unit) and m1 (program loader / debug DMA).

---
 rtl/mem_port_arbiter_if.sv | 46 ++++
 rtl/mem_port_arbiter.sv | 74 +++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the RAM port pins.
// master: environment side (requesters drive requests, RAM drives read data).
// slave:  arbiter side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_we, mem_addr, mem_din,
        output mem_dout
    );

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_we, mem_addr, mem_din,
        input  mem_dout
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of one block-RAM port.
// One access is granted per cycle; reads are tracked through a RD_LAT-deep
// pipe of {valid, id} so each read is handed back to its owner when the RAM
// data appears.
module mem_port_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int ARB_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    logic              any_gnt;
    logic              sel_m1;
    logic              win_we;
    logic              rd_in;
    logic              last_gnt;
    logic [RD_LAT-1:0] pipe_vld;
    logic [RD_LAT-1:0] pipe_id;

    // Pick the winner; in round-robin the requester not granted last wins a tie.
    always_comb begin
        any_gnt = !rst && (bus.m0_req || bus.m1_req);
        if (!bus.m0_req) begin
            sel_m1 = bus.m1_req;
        end else if (!bus.m1_req) begin
            sel_m1 = 1'b0;
        end else if (ARB_MODE == 1) begin
            sel_m1 = 1'b0;
        end else begin
            sel_m1 = !last_gnt;
        end
        win_we = sel_m1 ? bus.m1_we : bus.m0_we;
        rd_in  = any_gnt && !win_we;
    end

    // Grants and RAM port mux; idle cycles park the port on m0's signals.
    always_comb begin
        bus.m0_gnt   = any_gnt && !sel_m1;
        bus.m1_gnt   = any_gnt && sel_m1;
        bus.mem_we   = any_gnt && win_we;
        bus.mem_addr = (any_gnt && sel_m1) ? bus.m1_addr : bus.m0_addr;
        bus.mem_din  = (any_gnt && sel_m1) ? bus.m1_wdata : bus.m0_wdata;
    end

    // Arbitration history and read-tracking pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= 1'b1;
            pipe_vld <= '0;
            pipe_id  <= '0;
        end else begin
            if (any_gnt) begin
                last_gnt <= sel_m1;
            end
            pipe_vld[0] <= rd_in;
            pipe_id[0]  <= sel_m1;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_id[i]  <= pipe_id[i-1];
            end
        end
    end

    // Return path: RAM data goes to both owners, rvalid only to the tracked one.
    always_comb begin
        bus.m0_rvalid = !rst && pipe_vld[RD_LAT-1] && !pipe_id[RD_LAT-1];
        bus.m1_rvalid = !rst && pipe_vld[RD_LAT-1] && pipe_id[RD_LAT-1];
        bus.m0_rdata  = bus.mem_dout;
        bus.m1_rdata  = bus.mem_dout;
    end
endmodule
